sram_dp_param: RTL and testbench
================================

Name: sram_dp_param

Overview:
- Parametrised, single-clock, true dual-port synchronous SRAM behavioural model for the qlf_k6n10f BRAM flow.
- Extends the fixed 1024x18 dual-port model with configurable width and depth, a selectable read-during-write mode, and an optional output register.
- Adds a post-reset memory-clear sequencer, per-port read-valid strobes and write-collision detection.
- Instantiated by the BRAM techmap and by simulation benches as the golden RAM model.

Parameters:
- WIDTH, 18, data and mask width in bits (1..36).
- DEPTH, 1024, number of words (power of two, 16..4096).
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
- RDW_MODE, 0, same-port read-during-write: 0 = old data, 1 = write-through (new data), 2 = no-change (rdata holds).
- OUT_REG, 0, 1 adds one output pipeline register per port.
- INIT_VAL, 0, WIDTH-bit value written to every word by the clear sequencer.
- CLEAR_ON_RST, 1, 1 enables the clear sequencer after reset; 0 leaves contents X.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  asynchronous, active-high reset.
- cen_a  in  1  port A chip enable, active low.
- wen_a  in  1  port A write enable, active low; qualified by cen_a.
- addr_a  in  ADDR_W  port A word address.
- wmsk_a  in  WIDTH  port A bit mask; 1 = bit protected (not written).
- wdata_a  in  WIDTH  port A write data.
- rdata_a  out  WIDTH  port A read data.
- rvalid_a  out  1  port A read-data-valid strobe.
- cen_b, wen_b, addr_b, wmsk_b, wdata_b, rdata_b, rvalid_b: same as port A, for port B.
- busy  out  1  high while the clear sequencer runs; port requests are ignored.
- collision  out  1  one-cycle pulse on a same-address access conflict.

Behaviour:
- Reset (async, rst=1): rdata_a = rdata_b = 0, rvalid_a = rvalid_b = 0, collision = 0, pipeline registers = 0.
  - busy = CLEAR_ON_RST; FSM state = CLEAR if CLEAR_ON_RST = 1, else IDLE; clear counter = 0.
  - Array contents are not reset asynchronously.
- FSM, two states:
  - CLEAR: each clk, write INIT_VAL to address cnt, then cnt++. When cnt = DEPTH-1 is written, go to IDLE and drop busy on the next edge. Clearing takes exactly DEPTH cycles after rst deasserts.
  - IDLE: normal operation.
  - rst asserted mid-CLEAR restarts the sweep from address 0.
- A port request is accepted on a rising clk edge when cen_x = 0 and busy = 0. Requests while busy = 1 are dropped, with no rvalid.
- Write (cen = 0, wen = 0): for each bit i, mem[addr][i] = wmsk[i] ? old bit : wdata[i].
- Read (cen = 0): in the same edge, rdata_x and rvalid_x update.
  - OUT_REG = 0: latency 1 cycle.
  - OUT_REG = 1: latency 2 cycles; rvalid is pipelined identically.
- rvalid_x is asserted for every accepted request, read or write, except a write in RDW_MODE = 2.
- cen = 1 or busy = 1: rdata holds its last value; rvalid = 0.
- Same-port read-during-write (a write is also a read of the same address):
  - RDW_MODE 0: rdata = pre-write word.
  - RDW_MODE 1: rdata = merged post-write word.
  - RDW_MODE 2: rdata holds and rvalid = 0.
- Cross-port, same address, same edge:
  - A and B both write: port A wins for every bit A leaves unmasked; B's unmasked bits apply only where A's mask is 1. collision pulses.
  - One port writes, the other reads: the reader gets old data. collision pulses.
  - Both read: no collision.
- collision is registered: high for the cycle after the conflicting edge, aligned with OUT_REG = 0 timing.
- Addresses are always in range: DEPTH is a power of two and addresses wrap modulo DEPTH by width.

Decomposition:
- Package sram_dp_pkg: RDW_OLD = 0, RDW_NEW = 1, RDW_NOCHANGE = 2; FSM state enum (CLEAR, IDLE); helper function mask_merge(old, data, msk).
- Sub-module sram_dp_port_pipe, instantiated twice: output register, rvalid pipeline and RDW_MODE selection for one port.
- Array, arbitration and clear FSM stay in the top module.

Test Plan:
- Clear sequence: WIDTH = 18, DEPTH = 16, INIT_VAL = 18'h2AAAA; release rst -> busy high for exactly 16 cycles; then reading addresses 0..15 returns 18'h2AAAA with rvalid one cycle after each request.
- Masked write: A writes addr 5, wdata = 18'h3FFFF, wmsk = 18'h0FFFF; then A reads addr 5 -> rdata_a = 18'h30000 | (INIT_VAL & 18'h0FFFF).
- Read-during-write, all three modes, addr 3 holding 18'h00001, A writes 18'h00002:
  - RDW_MODE 0 -> rdata_a = 18'h00001.
  - RDW_MODE 1 -> rdata_a = 18'h00002.
  - RDW_MODE 2 -> rdata_a unchanged and rvalid_a = 0.
- Write-write collision: A writes 18'h11111 and B writes 18'h22222 to addr 7, both unmasked -> collision pulses for 1 cycle; a subsequent read of addr 7 returns 18'h11111.
- Latency: OUT_REG = 1; B reads addr 2 -> rvalid_b and rdata_b appear 2 cycles after the request; back-to-back reads of addrs 2, 3, 4 stream out one word per cycle.
- Reset mid-clear: assert rst at clear cycle 8, release -> busy lasts a full 16 cycles again; a request issued at busy = 1 produces no rvalid and leaves memory unchanged.

Source files
------------

// File: rtl/sram_dp_pkg.sv
// Shared constants, FSM encoding and the bit-mask merge helper for the
// parametrised true dual-port SRAM model.
package sram_dp_pkg;

  localparam int unsigned RDW_OLD      = 32'd0;
  localparam int unsigned RDW_NEW      = 32'd1;
  localparam int unsigned RDW_NOCHANGE = 32'd2;
  localparam int unsigned MAX_W        = 32'd36;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } sram_state_e;

  // A set mask bit protects the old bit; a clear one takes the new data bit.
  function automatic logic [MAX_W-1:0] mask_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] data_w,
    input logic [MAX_W-1:0] msk_w
  );
    return (old_w & msk_w) | (data_w & ~msk_w);
  endfunction

endpackage

// File: rtl/sram_dp_port_pipe.sv
// Per-port read path: read-during-write selection, read-data register,
// optional output pipeline stage and the matching rvalid pipeline.
module sram_dp_port_pipe
  import sram_dp_pkg::*;
#(
  parameter int unsigned WIDTH    = 32'd18,
  parameter int unsigned RDW_MODE = 32'd0,
  parameter int unsigned OUT_REG  = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic             is_wr,
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  logic [WIDTH-1:0] rd1_d, rd1_q;
  logic             rv1_d, rv1_q;

  // Writes in no-change mode leave the read register untouched and raise no strobe.
  always_comb begin
    rd1_d = rd1_q;
    rv1_d = 1'b0;
    if (acc) begin
      if (is_wr && (RDW_MODE == RDW_NOCHANGE)) begin
        rd1_d = rd1_q;
        rv1_d = 1'b0;
      end else if (is_wr && (RDW_MODE == RDW_NEW)) begin
        rd1_d = new_word;
        rv1_d = 1'b1;
      end else begin
        rd1_d = old_word;
        rv1_d = 1'b1;
      end
    end else begin
      rd1_d = rd1_q;
      rv1_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      rv1_q <= rv1_d;
    end
  end

  if (OUT_REG != 32'd0) begin : g_oreg
    logic [WIDTH-1:0] rd2_d, rd2_q;
    logic             rv2_d, rv2_q;

    assign rd2_d = rd1_q;
    assign rv2_d = rv1_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd2_q <= '0;
        rv2_q <= 1'b0;
      end else begin
        rd2_q <= rd2_d;
        rv2_q <= rv2_d;
      end
    end

    assign rdata  = rd2_q;
    assign rvalid = rv2_q;
  end else begin : g_noreg
    assign rdata  = rd1_q;
    assign rvalid = rv1_q;
  end

endmodule

// File: rtl/sram_dp_param.sv
// Parametrised single-clock true dual-port SRAM model with post-reset clear
// sequencer, per-port read-valid strobes and same-address collision flag.
module sram_dp_param
  import sram_dp_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32'd18,
  parameter int unsigned      DEPTH        = 32'd1024,
  parameter int unsigned      ADDR_W       = $clog2(DEPTH),
  parameter int unsigned      RDW_MODE     = 32'd0,
  parameter int unsigned      OUT_REG      = 32'd0,
  parameter logic [WIDTH-1:0] INIT_VAL     = '0,
  parameter bit               CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen_a,
  input  logic              wen_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  wmsk_a,
  input  logic [WIDTH-1:0]  wdata_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              cen_b,
  input  logic              wen_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wmsk_b,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b,
  output logic              busy,
  output logic              collision
);

  logic [WIDTH-1:0]  mem [DEPTH];
  sram_state_e       state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              coll_d, coll_q;

  logic              acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [WIDTH-1:0]  old_a, old_b, raw_b, base_a, new_a, new_b;

  function automatic logic [WIDTH-1:0] merge_w(
    input logic [WIDTH-1:0] o,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] m
  );
    logic [MAX_W-1:0] oo, dd, mm, rr;
    oo = '0;
    dd = '0;
    mm = '0;
    oo[WIDTH-1:0] = o;
    dd[WIDTH-1:0] = d;
    mm[WIDTH-1:0] = m;
    rr = mask_merge(oo, dd, mm);
    return rr[WIDTH-1:0];
  endfunction

  assign busy      = (state_q == CLEAR);
  assign collision = coll_q;

  // On a shared write address B is merged first so A overrides every bit it leaves unmasked.
  always_comb begin
    acc_a     = ~cen_a & ~busy;
    acc_b     = ~cen_b & ~busy;
    wr_a      = acc_a & ~wen_a;
    wr_b      = acc_b & ~wen_b;
    same_addr = (addr_a == addr_b);
    old_a     = mem[addr_a];
    old_b     = mem[addr_b];
    raw_b     = merge_w(old_b, wdata_b, wmsk_b);
    base_a    = (wr_b && same_addr) ? raw_b : old_a;
    new_a     = merge_w(base_a, wdata_a, wmsk_a);
    new_b     = (wr_a && same_addr) ? new_a : raw_b;
    coll_d    = acc_a & acc_b & same_addr & (wr_a | wr_b);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        state_d = IDLE;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR_ON_RST ? CLEAR : IDLE;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
    end
  end

  // Storage has no reset; contents come only from the clear sweep or port writes.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= INIT_VAL;
    end else begin
      if (wr_b) begin
        mem[addr_b] <= new_b;
      end
      if (wr_a) begin
        mem[addr_a] <= new_a;
      end
    end
  end

  sram_dp_port_pipe #(
    .WIDTH   (WIDTH),
    .RDW_MODE(RDW_MODE),
    .OUT_REG (OUT_REG)
  ) u_pipe_a (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc_a),
    .is_wr   (wr_a),
    .old_word(old_a),
    .new_word(new_a),
    .rdata   (rdata_a),
    .rvalid  (rvalid_a)
  );

  sram_dp_port_pipe #(
    .WIDTH   (WIDTH),
    .RDW_MODE(RDW_MODE),
    .OUT_REG (OUT_REG)
  ) u_pipe_b (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc_b),
    .is_wr   (wr_b),
    .old_word(old_b),
    .new_word(new_b),
    .rdata   (rdata_b),
    .rvalid  (rvalid_b)
  );

endmodule

// File: tb/tb_sram_dp_param.sv
// Bench for sram_dp_param: four instances (RDW modes 0/1/2, plus mode 0 with
// output register) share one stimulus stream and are checked against a word-level model.
module tb_sram_dp_param;

  localparam logic [17:0] INIT = 18'h2AAAA;

  logic        clk, rst;
  logic        cen_a, wen_a, cen_b, wen_b;
  logic [3:0]  addr_a, addr_b;
  logic [17:0] wmsk_a, wdata_a, wmsk_b, wdata_b;
  logic [17:0] rda [4];
  logic [17:0] rdb [4];
  logic        rva [4];
  logic        rvb [4];
  logic        bsy [4];
  logic        col [4];

  int total = 0;
  int bad   = 0;
  int cyc;
  bit chk_on = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_dp_param #(
      .WIDTH       (32'd18),
      .DEPTH       (32'd16),
      .RDW_MODE    ((g == 3) ? 32'd0 : 32'(g)),
      .OUT_REG     ((g == 3) ? 32'd1 : 32'd0),
      .INIT_VAL    (INIT),
      .CLEAR_ON_RST(1'b1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cen_a    (cen_a),
      .wen_a    (wen_a),
      .addr_a   (addr_a),
      .wmsk_a   (wmsk_a),
      .wdata_a  (wdata_a),
      .rdata_a  (rda[g]),
      .rvalid_a (rva[g]),
      .cen_b    (cen_b),
      .wen_b    (wen_b),
      .addr_b   (addr_b),
      .wmsk_b   (wmsk_b),
      .wdata_b  (wdata_b),
      .rdata_b  (rdb[g]),
      .rvalid_b (rvb[g]),
      .busy     (bsy[g]),
      .collision(col[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- word-level reference model ----------------
  logic [17:0] mm [16];
  int          clr_left;
  logic [17:0] e_rd_a [3];
  logic [17:0] e_rd_b [3];
  logic        e_v_a [3];
  logic        e_v_b [3];
  logic [17:0] e3_rd_a, e3_rd_b;
  logic        e3_v_a, e3_v_b, e_busy, e_col;

  function automatic logic [18:0] port_next(int m, logic acc, logic wr, logic [17:0] old_w,
                                            logic [17:0] post_w, logic [17:0] prev);
    if (!acc) return {1'b0, prev};
    if (wr && m == 2) return {1'b0, prev};
    if (wr && m == 1) return {1'b1, post_w};
    return {1'b1, old_w};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [18:0] r;
    logic        ac_a, ac_b, w_a, w_b;
    logic [17:0] o_a, o_b;
    if (rst) begin
      clr_left = 16;
      e_busy   = 1'b1;
      e_col    = 1'b0;
      e3_rd_a  = '0; e3_rd_b = '0; e3_v_a = 1'b0; e3_v_b = 1'b0;
      for (int m = 0; m < 3; m++) begin
        e_rd_a[m] = '0; e_rd_b[m] = '0; e_v_a[m] = 1'b0; e_v_b[m] = 1'b0;
      end
    end else begin
      e3_rd_a = e_rd_a[0]; e3_v_a = e_v_a[0];
      e3_rd_b = e_rd_b[0]; e3_v_b = e_v_b[0];
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) for (int k = 0; k < 16; k++) mm[k] = INIT;
        for (int m = 0; m < 3; m++) begin e_v_a[m] = 1'b0; e_v_b[m] = 1'b0; end
        e_col = 1'b0;
      end else begin
        ac_a = !cen_a; ac_b = !cen_b;
        w_a  = ac_a && !wen_a; w_b = ac_b && !wen_b;
        o_a  = mm[addr_a]; o_b = mm[addr_b];
        if (w_b) mm[addr_b] = (mm[addr_b] & wmsk_b) | (wdata_b & ~wmsk_b);
        if (w_a) mm[addr_a] = (mm[addr_a] & wmsk_a) | (wdata_a & ~wmsk_a);
        for (int m = 0; m < 3; m++) begin
          r = port_next(m, ac_a, w_a, o_a, mm[addr_a], e_rd_a[m]);
          e_v_a[m] = r[18]; e_rd_a[m] = r[17:0];
          r = port_next(m, ac_b, w_b, o_b, mm[addr_b], e_rd_b[m]);
          e_v_b[m] = r[18]; e_rd_b[m] = r[17:0];
        end
        e_col = ac_a && ac_b && (addr_a == addr_b) && (w_a || w_b);
      end
      e_busy = (clr_left > 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("u%0d.rdata_a", i), rda[i], (i == 3) ? e3_rd_a : e_rd_a[i]);
        chk($sformatf("u%0d.rvalid_a", i), rva[i], (i == 3) ? e3_v_a : e_v_a[i]);
        chk($sformatf("u%0d.rdata_b", i), rdb[i], (i == 3) ? e3_rd_b : e_rd_b[i]);
        chk($sformatf("u%0d.rvalid_b", i), rvb[i], (i == 3) ? e3_v_b : e_v_b[i]);
        chk($sformatf("u%0d.busy", i), bsy[i], e_busy);
        chk($sformatf("u%0d.collision", i), col[i], e_col);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    cen_a = 1'b1; wen_a = 1'b1; cen_b = 1'b1; wen_b = 1'b1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [17:0] m, input logic [17:0] d);
    cen_a = 1'b0; wen_a = 1'b0; addr_a = a; wmsk_a = m; wdata_a = d;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [17:0] m, input logic [17:0] d);
    cen_b = 1'b0; wen_b = 1'b0; addr_b = a; wmsk_b = m; wdata_b = d;
  endtask

  task automatic rd_a(input logic [3:0] a);
    cen_a = 1'b0; wen_a = 1'b1; addr_a = a;
  endtask

  task automatic rd_b(input logic [3:0] a);
    cen_b = 1'b0; wen_b = 1'b1; addr_b = a;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Counts cycles until busy falls; a request is parked on port A during two late busy edges.
  task automatic count_clear(output int n);
    n = 0;
    while (n < 64) begin
      step();
      n++;
      if (!bsy[0]) break;
      if (n == 13) wr_a(4'd3, 18'h00000, 18'h15555);
      if (n == 15) idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    addr_a = 4'd0; addr_b = 4'd0;
    wmsk_a = '0; wmsk_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (2) step();
    chk("rst_rdata_a", rda[0], 18'h00000);
    chk("rst_rvalid_b", rvb[0], 1'b0);
    chk("rst_busy", bsy[0], 1'b1);
    chk("rst_collision", col[0], 1'b0);
    chk_on = 1'b1;

    rst = 1'b0;
    count_clear(cyc);
    chk("clear_len", cyc, 16);

    for (int i = 0; i < 16; i++) begin
      rd_a(4'(i));
      rd_b(4'(15 - i));
      step();
      chk("clear_rdata_a", rda[0], INIT);
      chk("clear_rvalid_a", rva[0], 1'b1);
    end
    idle();
    step();

    wr_a(4'd5, 18'h0FFFF, 18'h3FFFF);
    step();
    rd_a(4'd5);
    step();
    chk("mask_write", rda[0], 18'h3AAAA);

    wr_a(4'd3, 18'h00000, 18'h00001);
    step();
    wr_a(4'd3, 18'h00000, 18'h00002);
    step();
    chk("rdw_old", rda[0], 18'h00001);
    chk("rdw_new", rda[1], 18'h00002);
    chk("rdw_hold", rda[2], 18'h3AAAA);
    chk("rdw_hold_rvalid", rva[2], 1'b0);
    idle();
    step();

    wr_a(4'd7, 18'h00000, 18'h11111);
    wr_b(4'd7, 18'h00000, 18'h22222);
    step();
    chk("ww_collision", col[0], 1'b1);
    idle();
    step();
    chk("collision_pulse", col[0], 1'b0);
    rd_a(4'd7);
    step();
    chk("ww_winner", rda[0], 18'h11111);

    wr_a(4'd8, 18'h3FF00, 18'h11111);
    wr_b(4'd8, 18'h00000, 18'h22222);
    step();
    idle();
    rd_a(4'd8);
    step();
    chk("ww_partial", rda[0], 18'h22211);

    wr_a(4'd9, 18'h00000, 18'h12345);
    rd_b(4'd9);
    step();
    chk("wr_reader_old", rdb[0], INIT);
    chk("wr_collision", col[0], 1'b1);
    idle();
    step();

    wr_a(4'd2, 18'h00000, 18'h00A02);
    step();
    wr_a(4'd4, 18'h00000, 18'h00A04);
    step();
    idle();
    rd_b(4'd2);
    step();
    chk("lat_c1_rvalid", rvb[3], 1'b0);
    rd_b(4'd3);
    step();
    chk("lat_c2_rvalid", rvb[3], 1'b1);
    chk("lat_c2_rdata", rdb[3], 18'h00A02);
    rd_b(4'd4);
    step();
    chk("lat_c3_rdata", rdb[3], 18'h00002);
    idle();
    step();
    chk("lat_c4_rdata", rdb[3], 18'h00A04);
    step();
    chk("lat_c5_rvalid", rvb[3], 1'b0);

    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_clear_busy", bsy[0], 1'b1);
    #2 rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear(cyc);
    chk("reclear_len", cyc, 16);
    rd_a(4'd3);
    rd_b(4'd9);
    step();
    chk("busy_write_dropped", rda[0], INIT);
    chk("reclear_rdata_b", rdb[0], INIT);
    idle();
    step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
